ib_vnu3_c2v_gather: RTL and testbench

//  Upstream feeder for the degree-3 IB variable-node cascade (f0/f1/f2 routes and c2v pipelines).

---
 rtl/ib_vnu3_c2v_gather.sv | 155 +++++++++++++++
 tb/tb_ib_vnu3_c2v_gather.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ib_vnu3_c2v_gather.sv
// Gathers E0/E1/E2 c2v messages and the channel LLR into one aligned bundle and
// queues it in a first-word-fall-through FIFO with a registered head.
module ib_vnu3_c2v_gather #(
   parameter int QUAN_SIZE  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = 3
) (
   input  logic                 read_clk,
   input  logic                 rstn,
   input  logic [QUAN_SIZE-1:0] c2v_in,
   input  logic [1:0]           c2v_layer,
   input  logic                 c2v_valid,
   output logic                 c2v_ready,
   input  logic [QUAN_SIZE-1:0] ch_llr_in,
   input  logic                 ch_valid,
   output logic                 ch_ready,
   input  logic                 iter_first,
   output logic [QUAN_SIZE-1:0] E0_out,
   output logic [QUAN_SIZE-1:0] E1_out,
   output logic [QUAN_SIZE-1:0] E2_out,
   output logic [QUAN_SIZE-1:0] ch_llr_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 err_layer
);

   localparam int                PTR_W    = LVL_W - 1;
   localparam int                BW       = 4 * QUAN_SIZE;
   localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

   logic [3:0]           flag_q, flag_d, flag_nx_s;
   logic [QUAN_SIZE-1:0] e0_q, e1_q, e2_q, ch_q;
   logic [QUAN_SIZE-1:0] e0_nx_s, e1_nx_s, e2_nx_s, ch_nx_s;
   logic                 err_q, err_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d, remain_s;
   logic [BW-1:0]        head_q, head_d, push_data_s;
   logic                 vld_q, vld_d;
   logic [BW-1:0]        mem [FIFO_DEPTH];

   logic slot_free_s, c2v_ready_s, ch_ready_s, c2v_acc_s, ch_acc_s;
   logic complete_s, pop_s, push_s;

   // Slot readiness and handshakes
   always_comb begin
      case (c2v_layer)
         2'd0:    slot_free_s = !flag_q[0];
         2'd1:    slot_free_s = !flag_q[1];
         2'd2:    slot_free_s = !flag_q[2];
         default: slot_free_s = 1'b0;
      endcase
      c2v_ready_s = !iter_first & slot_free_s;
      ch_ready_s  = !flag_q[3];
      c2v_acc_s   = c2v_valid & c2v_ready_s;
      ch_acc_s    = ch_valid & ch_ready_s;
   end

   // Next-flags/data including this cycle's accepts; completion and push decision
   always_comb begin
      flag_nx_s = flag_q;
      e0_nx_s   = e0_q;
      e1_nx_s   = e1_q;
      e2_nx_s   = e2_q;
      ch_nx_s   = ch_q;
      if (c2v_acc_s) begin
         case (c2v_layer)
            2'd0: begin flag_nx_s[0] = 1'b1; e0_nx_s = c2v_in; end
            2'd1: begin flag_nx_s[1] = 1'b1; e1_nx_s = c2v_in; end
            2'd2: begin flag_nx_s[2] = 1'b1; e2_nx_s = c2v_in; end
            default: begin end
         endcase
      end else begin
      end
      if (ch_acc_s) begin
         flag_nx_s[3] = 1'b1;
         ch_nx_s      = ch_llr_in;
      end else begin
      end
      complete_s = iter_first ? flag_nx_s[3] : (&flag_nx_s);
      pop_s      = vld_q & out_ready;
      // A full FIFO still accepts the push when its head leaves on the same edge
      push_s     = complete_s & ((level_q != FULL_LVL) | pop_s);
      if (iter_first) begin
         push_data_s = {{(3*QUAN_SIZE){1'b0}}, ch_nx_s};
      end else begin
         push_data_s = {e0_nx_s, e1_nx_s, e2_nx_s, ch_nx_s};
      end
      flag_d = push_s ? 4'b0000 : flag_nx_s;
      err_d  = err_q | (c2v_valid & (c2v_layer == 2'd3));
   end

   // FIFO pointers, level and next registered head
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      level_d  = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
      remain_s = level_q - LVL_W'(pop_s);
      if (remain_s != {LVL_W{1'b0}}) begin
         head_d = mem[rd_ptr_d];
      end else if (push_s) begin
         head_d = push_data_s;
      end else begin
         head_d = head_q;
      end
      vld_d = (level_d != {LVL_W{1'b0}});
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         flag_q   <= 4'b0000;
         e0_q     <= '0;
         e1_q     <= '0;
         e2_q     <= '0;
         ch_q     <= '0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         vld_q    <= 1'b0;
      end else begin
         flag_q   <= flag_d;
         e0_q     <= e0_nx_s;
         e1_q     <= e1_nx_s;
         e2_q     <= e2_nx_s;
         ch_q     <= ch_nx_s;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         vld_q    <= vld_d;
      end
   end

   // Bundle storage; contents are only meaningful behind valid pointers
   always_ff @(posedge read_clk) begin
      if (rstn && push_s) begin
         mem[wr_ptr_q] <= push_data_s;
      end
   end

   assign c2v_ready  = c2v_ready_s;
   assign ch_ready   = ch_ready_s;
   assign E0_out     = head_q[4*QUAN_SIZE-1 -: QUAN_SIZE];
   assign E1_out     = head_q[3*QUAN_SIZE-1 -: QUAN_SIZE];
   assign E2_out     = head_q[2*QUAN_SIZE-1 -: QUAN_SIZE];
   assign ch_llr_out = head_q[QUAN_SIZE-1:0];
   assign out_valid  = vld_q;
   assign fifo_level = level_q;
   assign err_layer  = err_q;

endmodule

// File: tb/tb_ib_vnu3_c2v_gather.sv
// Scoreboard bench for ib_vnu3_c2v_gather: slot-presence reference model, expected
// bundle queue filled by the driver and drained by an independent monitor.
module tb_ib_vnu3_c2v_gather;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] c2v_in = 4'd0;
   logic [1:0] c2v_layer = 2'd0;
   logic       c2v_valid = 1'b0;
   logic       c2v_ready;
   logic [3:0] ch_llr_in = 4'd0;
   logic       ch_valid = 1'b0;
   logic       ch_ready;
   logic       iter_first = 1'b0;
   logic [3:0] E0_out, E1_out, E2_out, ch_llr_out;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] fifo_level;
   logic       err_layer;

   ib_vnu3_c2v_gather dut (
      .read_clk(clk), .rstn(rstn),
      .c2v_in(c2v_in), .c2v_layer(c2v_layer), .c2v_valid(c2v_valid), .c2v_ready(c2v_ready),
      .ch_llr_in(ch_llr_in), .ch_valid(ch_valid), .ch_ready(ch_ready),
      .iter_first(iter_first),
      .E0_out(E0_out), .E1_out(E1_out), .E2_out(E2_out), .ch_llr_out(ch_llr_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .fifo_level(fifo_level), .err_layer(err_layer)
   );

   always #5 clk = ~clk;

   // Reference model state (written only by the driver)
   logic        have [4];
   logic [3:0]  val  [4];
   int          mdl_level = 0;
   logic        m_err = 1'b0;
   logic        exp_cr = 1'b0;
   logic        exp_chr = 1'b0;
   int          rst_epoch = 0;
   logic        mon_en = 1'b0;
   logic        done = 1'b0;
   logic [15:0] expq [$];

   // Counters (written only by the monitor)
   int n_tests = 0;
   int n_fail  = 0;

   task automatic model_update();
      logic pop, push, complete;
      if (!rstn) begin
         for (int k = 0; k < 4; k++) begin have[k] = 1'b0; val[k] = 4'd0; end
         expq.delete();
         mdl_level = 0;
         m_err = 1'b0;
         rst_epoch++;
      end else begin
         pop  = out_ready && (mdl_level > 0);
         push = 1'b0;
         if (c2v_valid && c2v_layer == 2'd3) m_err = 1'b1;
         if (c2v_valid && exp_cr) begin have[c2v_layer] = 1'b1; val[c2v_layer] = c2v_in; end
         if (ch_valid && exp_chr) begin have[3] = 1'b1; val[3] = ch_llr_in; end
         complete = iter_first ? have[3] : (have[0] && have[1] && have[2] && have[3]);
         if (complete && (mdl_level < 4 || pop)) begin
            if (iter_first) expq.push_back({12'h000, val[3]});
            else            expq.push_back({val[0], val[1], val[2], val[3]});
            for (int k = 0; k < 4; k++) have[k] = 1'b0;
            push = 1'b1;
         end
         mdl_level = mdl_level + (push ? 1 : 0) - (pop ? 1 : 0);
      end
   endtask

   task automatic step(input logic cv, input logic [1:0] cl, input logic [3:0] cd,
                       input logic hv, input logic [3:0] hd, input logic itf, input logic ordy);
      c2v_valid = cv; c2v_layer = cl; c2v_in = cd;
      ch_valid = hv; ch_llr_in = hd; iter_first = itf; out_ready = ordy;
      exp_cr  = !itf && (cl != 2'd3) && !have[cl];
      exp_chr = !have[3];
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0, ordy);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle(1'b0, 1);
      rstn = 1'b1;
   endtask

   // Three-step full bundle: E0 with ch, then E1, then E2
   task automatic bundle(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] h, input logic ordy);
      step(1'b1, 2'd0, a, 1'b1, h, 1'b0, ordy);
      step(1'b1, 2'd1, b, 1'b0, 4'd0, 1'b0, ordy);
      step(1'b1, 2'd2, c, 1'b0, 4'd0, 1'b0, ordy);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: directed scenarios then randomized traffic
   initial begin
      for (int k = 0; k < 4; k++) begin have[k] = 1'b0; val[k] = 4'd0; end
      do_reset();
      mon_en = 1'b1;
      idle(1'b1, 2);
      // Out-of-order single pieces
      step(1'b1, 2'd2, 4'd5,  1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 4'd0,  1'b1, 4'd9, 1'b0, 1'b1);
      step(1'b1, 2'd0, 4'd1,  1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b1, 2'd1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b1);
      idle(1'b1, 3);
      // Concurrent c2v+ch, and a repeat to a filled slot
      step(1'b1, 2'd1, 4'd7, 1'b1, 4'd3, 1'b0, 1'b1);
      step(1'b1, 2'd0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b1, 2'd1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b1, 2'd2, 4'd4, 1'b0, 4'd0, 1'b0, 1'b1);
      idle(1'b1, 3);
      // First iteration: channel-only bundle
      step(1'b1, 2'd0, 4'd8, 1'b1, 4'd6, 1'b1, 1'b1);
      idle(1'b1, 3);
      // Fill the FIFO, hold a fifth gather, then pop+push on one edge
      for (int b = 0; b < 5; b++)
         bundle(4'(b), 4'(b + 4), 4'(b + 8), 4'(15 - b), 1'b0);
      idle(1'b0, 2);
      idle(1'b1, 1);
      idle(1'b0, 1);
      idle(1'b1, 6);
      // Illegal layer is sticky
      step(1'b1, 2'd3, 4'd11, 1'b0, 4'd0, 1'b0, 1'b1);
      idle(1'b1, 3);
      // Reset with queued and partial data
      bundle(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      bundle(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
      step(1'b1, 2'd0, 4'd9, 1'b1, 4'd10, 1'b0, 1'b0);
      do_reset();
      idle(1'b1, 3);
      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         step(1'($urandom_range(0, 1)),
              2'(($urandom_range(0, 24) == 0) ? 3 : $urandom_range(0, 2)),
              4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 9) < 7));
      end
      idle(1'b1, 8);
      done = 1'b1;
   end

   // Monitor: compares DUT against the model on the falling edge
   initial begin
      logic [15:0] head;
      logic [15:0] last_seen;
      int          seen_epoch;
      last_seen  = 16'h0000;
      seen_epoch = 0;
      wait (mon_en);
      while (!done) begin
         @(negedge clk);
         if (rst_epoch != seen_epoch) begin
            last_seen  = 16'h0000;
            seen_epoch = rst_epoch;
         end
         head = {E0_out, E1_out, E2_out, ch_llr_out};
         chk("c2v_ready",  16'(c2v_ready),  16'(exp_cr));
         chk("ch_ready",   16'(ch_ready),   16'(exp_chr));
         chk("fifo_level", 16'(fifo_level), 16'(mdl_level));
         chk("out_valid",  16'(out_valid),  16'(mdl_level != 0));
         chk("err_layer",  16'(err_layer),  16'(m_err));
         if (out_valid) begin
            if (expq.size() > 0) begin
               chk("head", head, expq[0]);
               if (out_ready) void'(expq.pop_front());
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL head_unexpected: got %0h expected no bundle at %0t", head, $time);
            end
            last_seen = head;
         end else begin
            chk("head_hold", head, last_seen);
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
